// File: rtl/fault_campaign_seq_if.sv
// Fault-campaign control/observe bundle between the sequencer and the faulted netlist harness.
// Pure wiring; no storage or latency of its own.
// No backpressure: all signals are level/pulse, sampled every clock.
interface fault_campaign_seq_if #(
  parameter int NSITES = 16,
  parameter int WIDTH  = 8
);
  localparam int NF = 2 * NSITES;
  localparam int FW = (NF > 1) ? $clog2(NF) : 1;
  localparam int CW = $clog2(NF + 1);

  logic              start;
  logic [WIDTH-1:0]  dut_out;
  logic [WIDTH-1:0]  gold_out;
  logic [NSITES-1:0] stuck0;
  logic [NSITES-1:0] stuck1;
  logic              dut_rst;
  logic              busy;
  logic              done;
  logic [FW-1:0]     cur_fault;
  logic [NF-1:0]     det_map;
  logic [CW-1:0]     det_count;

  // Sequencer side: observes the netlist, drives the fault controls and results.
  modport master (
    input  start, dut_out, gold_out,
    output stuck0, stuck1, dut_rst, busy, done, cur_fault, det_map, det_count
  );

  // Harness side: starts campaigns, feeds outputs back, consumes results.
  modport slave (
    output start, dut_out, gold_out,
    input  stuck0, stuck1, dut_rst, busy, done, cur_fault, det_map, det_count
  );
endinterface

// File: rtl/fault_campaign_seq.sv
// Stuck-at fault campaign sequencer: walks every site/polarity, resets DUT+golden, compares for WINDOW cycles.
// Campaign takes 2*NSITES*(2+WINDOW) busy cycles; done pulses one cycle later (less with early abort).
// No backpressure; start is ignored while busy. Optional macro FAULT_EARLY_ABORT_EN ends a window on first mismatch.
module fault_campaign_seq #(
  parameter int NSITES = 16,
  parameter int WINDOW = 64,
  parameter int WIDTH  = 8
) (
  input logic                clk,
  input logic                rst,
  fault_campaign_seq_if.master bus
);
  localparam int NF = 2 * NSITES;
  localparam int FW = (NF > 1) ? $clog2(NF) : 1;
  localparam int CW = $clog2(NF + 1);
  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRST = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_pcnt;
  logic              w_pcnt_nxt;
  logic [WW-1:0]     r_win;
  logic [WW-1:0]     w_win_nxt;
  logic [FW-1:0]     r_fault;
  logic [FW-1:0]     w_fault_nxt;
  logic [NF-1:0]     r_det_map;
  logic [CW-1:0]     r_det_count;
  logic [NSITES-1:0] r_stuck0;
  logic [NSITES-1:0] r_stuck1;
  logic [NSITES-1:0] w_site_oh;
  logic              w_mis;
  logic              w_last_fault;
  logic              w_win_end;
  logic              w_clear;
  logic              w_det_new;

  // A mismatch only counts while a fault is actually applied.
  assign w_mis        = (r_state == S_RUN) && (bus.dut_out != bus.gold_out);
  assign w_last_fault = (r_fault == FW'(NF - 1));
  assign w_det_new    = w_mis && !r_det_map[r_fault];

`ifdef FAULT_EARLY_ABORT_EN
  // First mismatch already proves detection, so the rest of the window is skipped.
  assign w_win_end = (r_win == WW'(WINDOW - 1)) || w_mis;
`else
  assign w_win_end = (r_win == WW'(WINDOW - 1));
`endif

  // Site select for the fault about to be applied: site is the fault index without its polarity bit.
  assign w_site_oh = NSITES'(1) << (w_fault_nxt >> 1);

  // Next-state, window/pre-reset counters and fault index advance.
  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_win_nxt   = r_win;
    w_fault_nxt = r_fault;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_PRST;
          w_pcnt_nxt  = 1'b0;
          w_fault_nxt = '0;
          w_clear     = 1'b1;
        end
      end
      S_PRST: begin
        if (r_pcnt) begin
          w_state_nxt = S_RUN;
          w_win_nxt   = '0;
        end else begin
          w_pcnt_nxt = 1'b1;
        end
      end
      S_RUN: begin
        if (w_win_end) begin
          if (w_last_fault) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_PRST;
            w_pcnt_nxt  = 1'b0;
            w_fault_nxt = r_fault + 1'b1;
          end
        end else begin
          w_win_nxt = r_win + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and detection results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pcnt      <= 1'b0;
      r_win       <= '0;
      r_fault     <= '0;
      r_det_map   <= '0;
      r_det_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_win   <= w_win_nxt;
      r_fault <= w_fault_nxt;
      if (w_clear) begin
        r_det_map   <= '0;
        r_det_count <= '0;
      end else if (w_det_new) begin
        r_det_map[r_fault] <= 1'b1;
        r_det_count        <= r_det_count + 1'b1;
      end
    end
  end

  // Fault enables are registered from the next state so the fault is live from the first RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stuck0 <= '0;
      r_stuck1 <= '0;
    end else if (w_state_nxt == S_RUN) begin
      r_stuck0 <= w_fault_nxt[0] ? '0 : w_site_oh;
      r_stuck1 <= w_fault_nxt[0] ? w_site_oh : '0;
    end else begin
      r_stuck0 <= '0;
      r_stuck1 <= '0;
    end
  end

  assign bus.stuck0    = r_stuck0;
  assign bus.stuck1    = r_stuck1;
  assign bus.dut_rst   = (r_state == S_PRST);
  assign bus.busy      = (r_state == S_PRST) || (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.cur_fault = r_fault;
  assign bus.det_map   = r_det_map;
  assign bus.det_count = r_det_count;

endmodule

// File: tb/tb_fault_campaign_seq.sv
`timescale 1ns/1ps
module tb_fault_campaign_seq;
  localparam int NSITES = 4;
  localparam int WINDOW = 8;
  localparam int WIDTH  = 8;
  localparam int NF     = 2 * NSITES;

  typedef logic [NF-1:0][WINDOW-1:0] pset_t;
  typedef struct { int done_cyc; logic [NF-1:0] map; int count; } exp_t;
  typedef struct { int fault; int len; } win_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  exp_t  exp_q[$];
  win_t  win_q[$];
  pset_t pat_q[$];

  fault_campaign_seq_if #(.NSITES(NSITES), .WIDTH(WIDTH)) bus ();

  fault_campaign_seq #(.NSITES(NSITES), .WINDOW(WINDOW), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Window length per fault: full window, or up to and including the first mismatch when aborting early.
  function automatic int win_len(input logic [WINDOW-1:0] p);
`ifdef FAULT_EARLY_ABORT_EN
    for (int k = 0; k < WINDOW; k++) if (p[k]) return k + 1;
`endif
    return WINDOW;
  endfunction

  function automatic int decode(input logic [NSITES-1:0] s0, input logic [NSITES-1:0] s1);
    for (int s = 0; s < NSITES; s++) begin
      if (s0[s]) return 2 * s;
      if (s1[s]) return 2 * s + 1;
    end
    return -1;
  endfunction

  function automatic pset_t rand_pset();
    pset_t p;
    for (int f = 0; f < NF; f++) begin
      case ($urandom_range(3, 0))
        0, 1:    p[f] = '0;
        2:       p[f] = WINDOW'(1) << $urandom_range(WINDOW - 1, 0);
        default: p[f] = WINDOW'($urandom);
      endcase
    end
    return p;
  endfunction

  // Reference model: a fault is detected iff its mismatch pattern is non-empty; timing is a sum of window costs.
  task automatic push_campaign(input pset_t p, input int c, input bit expect_done, output int done_cyc);
    exp_t e;
    win_t w;
    int   tot;
    tot     = 0;
    e.map   = '0;
    e.count = 0;
    for (int f = 0; f < NF; f++) begin
      e.map[f] = |p[f];
      if (|p[f]) e.count++;
      w.fault = f;
      w.len   = win_len(p[f]);
      tot    += 2 + w.len;
      win_q.push_back(w);
    end
    e.done_cyc = c + 1 + tot;
    done_cyc   = e.done_cyc;
    pat_q.push_back(p);
    if (expect_done) exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy=%0b done=%0b after %0d cycles", bus.busy, bus.done, n);
    end
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: %0d campaigns never signalled done", exp_q.size());
      exp_q.delete();
      win_q.delete();
    end
  endtask

  task automatic launch(input pset_t p, input bit expect_done, input bit hold, output int c, output int d);
    wait_idle();
    bus.start = 1'b1;
    c = cyc;
    push_campaign(p, c, expect_done, d);
    if (!hold) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  // Faulted-netlist model: mismatches follow the pattern of the applied fault; random noise outside RUN must be ignored.
  initial begin
    pset_t            cur;
    logic             prev_busy;
    logic             prev_run;
    int               off;
    int               f;
    logic             mis;
    logic [WIDTH-1:0] g;
    cur          = '0;
    prev_busy    = 1'b0;
    prev_run     = 1'b0;
    off          = 0;
    bus.dut_out  = '0;
    bus.gold_out = '0;
    forever begin
      @(negedge clk);
      if (bus.busy && !prev_busy && pat_q.size() > 0) cur = pat_q.pop_front();
      prev_busy = bus.busy;
      g = WIDTH'($urandom);
      if ((bus.stuck0 | bus.stuck1) != '0) begin
        f        = decode(bus.stuck0, bus.stuck1);
        off      = prev_run ? off + 1 : 0;
        prev_run = 1'b1;
        mis      = (off < WINDOW && f >= 0) ? cur[f][off] : 1'b0;
      end else begin
        prev_run = 1'b0;
        mis      = ($urandom_range(1, 0) == 1);
      end
      bus.gold_out = g;
      bus.dut_out  = mis ? (g ^ WIDTH'($urandom_range((1 << WIDTH) - 1, 1))) : g;
    end
  end

  // Monitor: per-cycle phase invariants, per-window fault/length, and end-of-campaign results.
  initial begin
    logic              prev_run;
    logic              run;
    logic              ok;
    int                run_len;
    logic [2*NSITES-1:0] run_stuck;
    logic [2*NSITES-1:0] s;
    exp_t              e;
    win_t              w;
    prev_run  = 1'b0;
    run_len   = 0;
    run_stuck = '0;
    forever begin
      @(negedge clk);
      s  = {bus.stuck1, bus.stuck0};
      ok = 1'b1;
      if (!bus.busy && (s != '0 || bus.dut_rst)) ok = 1'b0;
      if (bus.dut_rst && (s != '0 || !bus.busy)) ok = 1'b0;
      if (bus.busy && !bus.dut_rst && !$onehot(s)) ok = 1'b0;
      if (bus.done && bus.busy) ok = 1'b0;
      chk("phase", {60'd0, bus.busy, bus.dut_rst, bus.done, ok}, {60'd0, bus.busy, bus.dut_rst, bus.done, 1'b1});

      run = (s != '0);
      if (run && !prev_run) begin
        run_len   = 1;
        run_stuck = s;
        if (win_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL win_unexpected: fault %0d applied with nothing expected", decode(bus.stuck0, bus.stuck1));
        end else begin
          chk("win_fault", 64'(decode(bus.stuck0, bus.stuck1)), 64'(win_q[0].fault));
          chk("cur_fault", 64'(bus.cur_fault), 64'(win_q[0].fault));
        end
      end else if (run) begin
        run_len++;
        chk("win_stable", 64'(s), 64'(run_stuck));
      end else if (prev_run && win_q.size() > 0) begin
        w = win_q.pop_front();
        chk($sformatf("win_len[%0d]", w.fault), 64'(run_len), 64'(w.len));
      end
      prev_run = run;
      if (rst) prev_run = 1'b0;

      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: done at cycle %0d with no campaign pending", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_cyc", 64'(cyc), 64'(e.done_cyc));
          chk("det_map", 64'(bus.det_map), 64'(e.map));
          chk("det_count", 64'(bus.det_count), 64'(e.count));
          chk("done_busy", 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    pset_t p;
    pset_t pb;
    int    c;
    int    d;
    int    d2;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stuck0", 64'(bus.stuck0), 64'd0);
    chk("rst_stuck1", 64'(bus.stuck1), 64'd0);
    chk("rst_dut_rst", 64'(bus.dut_rst), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_cur_fault", 64'(bus.cur_fault), 64'd0);
    chk("rst_det_map", 64'(bus.det_map), 64'd0);
    chk("rst_det_count", 64'(bus.det_count), 64'd0);
    rst = 1'b0;

    // No mismatches at all.
    p = '0;
    launch(p, 1'b1, 1'b0, c, d);
    wait_drain();

    // Only stuck-1 at site 2 is observable; a start pulse mid-campaign must be ignored.
    p = '0;
    p[5] = '1;
    launch(p, 1'b1, 1'b0, c, d);
    wait_cyc(c + 20);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();

    // Mismatch only on the first RUN cycle of fault 0.
    p = '0;
    p[0] = WINDOW'(1);
    launch(p, 1'b1, 1'b0, c, d);
    wait_drain();

    // Reset mid-campaign aborts with everything cleared and no done pulse.
    p = rand_pset();
    launch(p, 1'b0, 1'b0, c, d);
    wait_cyc(c + 30);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_stuck", 64'({bus.stuck1, bus.stuck0}), 64'd0);
    chk("abort_dut_rst", 64'(bus.dut_rst), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    chk("abort_cur_fault", 64'(bus.cur_fault), 64'd0);
    chk("abort_det_map", 64'(bus.det_map), 64'd0);
    chk("abort_det_count", 64'(bus.det_count), 64'd0);
    win_q.delete();

    // Full campaign after the abort.
    p = rand_pset();
    launch(p, 1'b1, 1'b0, c, d);
    wait_drain();

    // start held across DONE: back-to-back campaigns, second must begin from cleared results.
    p = rand_pset();
    p[6] = '1;
    pb = '0;
    pb[3] = WINDOW'(4);
    launch(p, 1'b1, 1'b1, c, d);
    push_campaign(pb, d + 1, 1'b1, d2);
    wait_cyc(d + 4);
    bus.start = 1'b0;
    wait_drain();

    // Randomised campaigns.
    for (int i = 0; i < 5; i++) begin
      p = rand_pset();
      launch(p, 1'b1, 1'b0, c, d);
      wait_drain();
    end

    repeat (3) @(negedge clk);
    chk("win_q_empty", 64'(win_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
